// File: rtl/config_bus_writer.sv
// Serial config stream to decoder-bus writer.
// Ports: prog_clk/prog_rst_n, bit_in/valid/ready, cfg_abort, enable/address/data_in, busy/done.
module config_bus_writer #(
  parameter int ADDR_WIDTH = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  prog_clk,
  input  logic                  prog_rst_n,
  input  logic                  bit_in,
  input  logic                  bit_valid,
  output logic                  bit_ready,
  input  logic                  cfg_abort,
  output logic                  enable,
  output logic [0:ADDR_WIDTH-1] address,
  output logic                  data_in,
  output logic                  busy,
  output logic                  done
);

  localparam int MAXW = (ADDR_WIDTH > CNT_WIDTH) ?
                        ADDR_WIDTH : CNT_WIDTH;
  localparam int BW   = $clog2(MAXW + 1);

  typedef enum logic [2:0] {
    IDLE, HDR_ADDR, HDR_CNT, DATA, SETUP, STROBE, DONE
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] oaddr_q, oaddr_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d, cnt_sh;
  logic [BW-1:0]         bcnt_q, bcnt_d;
  logic                  odata_q, odata_d;
  logic                  fire;

  // Gating with reset keeps ready low while held in reset.
  assign bit_ready = prog_rst_n & ~cfg_abort &
                     (state_q inside {IDLE, HDR_ADDR,
                                      HDR_CNT, DATA});
  assign fire    = bit_valid & bit_ready;
  assign enable  = (state_q == STROBE);
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign address = oaddr_q;
  assign data_in = odata_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    bcnt_d  = bcnt_q;
    oaddr_d = oaddr_q;
    odata_d = odata_q;
    cnt_sh  = (cnt_q << 1) | CNT_WIDTH'(bit_in);
    if (cfg_abort) begin
      state_d = IDLE;
      bcnt_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (fire && bit_in) begin
            state_d = HDR_ADDR;
            bcnt_d  = '0;
          end
        end
        HDR_ADDR: begin
          if (fire) begin
            addr_d = (addr_q << 1) | ADDR_WIDTH'(bit_in);
            if (bcnt_q == BW'(ADDR_WIDTH - 1)) begin
              bcnt_d  = '0;
              state_d = HDR_CNT;
            end else begin
              bcnt_d = bcnt_q + BW'(1);
            end
          end
        end
        HDR_CNT: begin
          if (fire) begin
            cnt_d = cnt_sh;
            if (bcnt_q == BW'(CNT_WIDTH - 1)) begin
              bcnt_d  = '0;
              state_d = (cnt_sh == '0) ? DONE : DATA;
            end else begin
              bcnt_d = bcnt_q + BW'(1);
            end
          end
        end
        DATA: begin
          // Output regs load here so the bus is stable
          // across SETUP and STROBE.
          if (fire) begin
            oaddr_d = addr_q;
            odata_d = bit_in;
            state_d = SETUP;
          end
        end
        SETUP: state_d = STROBE;
        STROBE: begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
          cnt_d   = cnt_q - CNT_WIDTH'(1);
          state_d = (cnt_q == CNT_WIDTH'(1)) ? DONE : DATA;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      oaddr_q <= '0;
      cnt_q   <= '0;
      bcnt_q  <= '0;
      odata_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      oaddr_q <= oaddr_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      odata_q <= odata_d;
    end
  end

endmodule

// File: tb/tb_config_bus_writer.sv
// Directed bench for config_bus_writer.
// Scenario tasks run in sequence from one initial block.
module tb_config_bus_writer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       bit_in;
  logic       bit_valid;
  logic       bit_ready;
  logic       cfg_abort;
  logic       enable;
  logic [0:3] address;
  logic       data_in;
  logic       busy;
  logic       done;

  int checks = 0;
  int passes = 0;

  logic [3:0] wa[$];
  logic       wd[$];
  int         dones = 0;
  int         viol  = 0;
  logic       prev_rdy = 1'b0;

  always #5 clk = ~clk;

  config_bus_writer #(.ADDR_WIDTH(4), .CNT_WIDTH(8)) dut (
    .prog_clk  (clk),
    .prog_rst_n(rst_n),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .cfg_abort (cfg_abort),
    .enable    (enable),
    .address   (address),
    .data_in   (data_in),
    .busy      (busy),
    .done      (done)
  );

  always @(negedge clk) begin
    if (enable) begin
      wa.push_back(address);
      wd.push_back(data_in);
    end
    if ((enable && (prev_rdy || bit_ready)) ||
        (done && bit_ready))
      viol <= viol + 1;
    if (done) dones <= dones + 1;
    prev_rdy <= bit_ready;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [31:0] v,
                           input int n, input bit rnd);
    int g;
    for (int i = n - 1; i >= 0; i--) begin
      if (rnd)
        while ($urandom_range(0, 1) == 1) begin
          bit_valid = 1'b0;
          bit_in    = 1'($urandom);
          step();
        end
      bit_in    = v[i];
      bit_valid = 1'b1;
      g = 0;
      while (!bit_ready && g < 50) begin
        step();
        g++;
      end
      if (!bit_ready) begin
        checks++;
        $display("FAIL handshake_timeout ready=%b want 1",
                 bit_ready);
      end
      step();
      bit_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int g = 0;
    while (busy && g < 40) begin
      step();
      g++;
    end
    checks++;
    if (busy !== 1'b0)
      $display("FAIL idle_timeout busy=%b want 0", busy);
    else passes++;
    step();
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks += 6;
    if (enable !== 1'b0)
      $display("FAIL rst_enable got %b want 0", enable);
    else passes++;
    if (address !== 4'd0)
      $display("FAIL rst_address got %0d want 0", address);
    else passes++;
    if (data_in !== 1'b0)
      $display("FAIL rst_data got %b want 0", data_in);
    else passes++;
    if (busy !== 1'b0)
      $display("FAIL rst_busy got %b want 0", busy);
    else passes++;
    if (done !== 1'b0)
      $display("FAIL rst_done got %b want 0", done);
    else passes++;
    if (bit_ready !== 1'b0)
      $display("FAIL rst_ready got %b want 0", bit_ready);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks += 2;
    if (bit_ready !== 1'b1)
      $display("FAIL post_rst_ready got %b want 1", bit_ready);
    else passes++;
    if (busy !== 1'b0)
      $display("FAIL post_rst_busy got %b want 0", busy);
    else passes++;
  endtask

  task automatic run_frame(input string nm,
                           input logic [3:0] a,
                           input logic [2:0] d,
                           input logic [3:0] e0,
                           input logic [3:0] e1,
                           input logic [3:0] e2,
                           input bit rnd);
    int wb = wa.size();
    int db = dones;
    int vb = viol;
    logic [3:0] ea[3];
    logic       ed[3];
    ea[0] = e0; ea[1] = e1; ea[2] = e2;
    ed[0] = d[2]; ed[1] = d[1]; ed[2] = d[0];
    send_bits(32'b001, 3, rnd);
    send_bits({28'd0, a}, 4, rnd);
    send_bits(32'd3, 8, rnd);
    send_bits({29'd0, d}, 3, rnd);
    wait_idle();
    checks++;
    if (wa.size() - wb !== 3)
      $display("FAIL %s_nwrites got %0d want 3",
               nm, wa.size() - wb);
    else passes++;
    for (int i = 0; i < 3; i++) begin
      checks += 2;
      if (wa[wb+i] !== ea[i])
        $display("FAIL %s_addr%0d got %0d want %0d",
                 nm, i, wa[wb+i], ea[i]);
      else passes++;
      if (wd[wb+i] !== ed[i])
        $display("FAIL %s_data%0d got %b want %b",
                 nm, i, wd[wb+i], ed[i]);
      else passes++;
    end
    checks += 2;
    if (dones - db !== 1)
      $display("FAIL %s_dones got %0d want 1", nm, dones - db);
    else passes++;
    if (viol - vb !== 0)
      $display("FAIL %s_ready_hi got %0d want 0", nm, viol - vb);
    else passes++;
  endtask

  task automatic test_zero_count();
    int wb = wa.size();
    int db = dones;
    send_bits(32'b1, 1, 0);
    send_bits(32'b1010, 4, 0);
    send_bits(32'd0, 8, 0);
    checks += 2;
    if (done !== 1'b1)
      $display("FAIL zc_done got %b want 1", done);
    else passes++;
    if (busy !== 1'b1)
      $display("FAIL zc_busy got %b want 1", busy);
    else passes++;
    step();
    step();
    checks += 4;
    if (done !== 1'b0)
      $display("FAIL zc_done_after got %b want 0", done);
    else passes++;
    if (busy !== 1'b0)
      $display("FAIL zc_idle got %b want 0", busy);
    else passes++;
    if (wa.size() - wb !== 0)
      $display("FAIL zc_writes got %0d want 0", wa.size() - wb);
    else passes++;
    if (dones - db !== 1)
      $display("FAIL zc_dones got %0d want 1", dones - db);
    else passes++;
  endtask

  task automatic test_abort();
    int wb = wa.size();
    int db = dones;
    int g  = 0;
    send_bits(32'b1, 1, 0);
    send_bits(32'b0101, 4, 0);
    send_bits(32'd3, 8, 0);
    send_bits(32'b1, 1, 0);
    while (!bit_ready && g < 20) begin
      step();
      g++;
    end
    bit_in    = 1'b0;
    bit_valid = 1'b1;
    cfg_abort = 1'b1;
    #1;
    checks++;
    if (bit_ready !== 1'b0)
      $display("FAIL ab_ready got %b want 0", bit_ready);
    else passes++;
    step();
    cfg_abort = 1'b0;
    bit_valid = 1'b0;
    checks++;
    if (busy !== 1'b0)
      $display("FAIL ab_idle got %b want 0", busy);
    else passes++;
    step();
    step();
    step();
    checks += 5;
    if (wa.size() - wb !== 1)
      $display("FAIL ab_writes got %0d want 1", wa.size() - wb);
    else passes++;
    if (wa[wb] !== 4'd5)
      $display("FAIL ab_addr got %0d want 5", wa[wb]);
    else passes++;
    if (dones - db !== 0)
      $display("FAIL ab_dones got %0d want 0", dones - db);
    else passes++;
    if (address !== 4'd5)
      $display("FAIL ab_hold_addr got %0d want 5", address);
    else passes++;
    if (data_in !== 1'b1)
      $display("FAIL ab_hold_data got %b want 1", data_in);
    else passes++;
  endtask

  task automatic test_reset_strobe();
    int wb;
    int g = 0;
    send_bits(32'b1, 1, 0);
    send_bits(32'b0101, 4, 0);
    send_bits(32'd3, 8, 0);
    send_bits(32'b1, 1, 0);
    while (!enable && g < 10) begin
      step();
      g++;
    end
    checks++;
    if (enable !== 1'b1)
      $display("FAIL rs_strobe got %b want 1", enable);
    else passes++;
    wb = wa.size();
    #1;
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (enable !== 1'b0)
      $display("FAIL rs_enable got %b want 0", enable);
    else passes++;
    if (busy !== 1'b0)
      $display("FAIL rs_busy got %b want 0", busy);
    else passes++;
    if (address !== 4'd0)
      $display("FAIL rs_address got %0d want 0", address);
    else passes++;
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks += 2;
    if (wa.size() - wb !== 0)
      $display("FAIL rs_writes got %0d want 0", wa.size() - wb);
    else passes++;
    if (bit_ready !== 1'b1)
      $display("FAIL rs_ready got %b want 1", bit_ready);
    else passes++;
    run_frame("rs_frame", 4'b0101, 3'b101,
              4'd5, 4'd6, 4'd7, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    cfg_abort = 1'b0;
    test_reset();
    run_frame("basic", 4'b0101, 3'b101,
              4'd5, 4'd6, 4'd7, 0);
    run_frame("wrap", 4'b1111, 3'b110,
              4'd15, 4'd0, 4'd1, 0);
    test_zero_count();
    run_frame("stall", 4'b0101, 3'b101,
              4'd5, 4'd6, 4'd7, 1);
    test_abort();
    test_reset_strobe();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/config_bus_writer.md
CONFIG_BUS_WRITER -- requirements
Module: config_bus_writer

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 4: width of the configuration address bus.
REQ-002 The block SHALL have parameter CNT_WIDTH, default 8: width of the frame bit-count field.
REQ-003 prog_clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 prog_rst_n  input  1  reset, asynchronous and active-low.
REQ-005 bit_in  input  1  serial configuration stream bit.
REQ-006 bit_valid  input  1  bit_in is valid this cycle.
REQ-007 bit_ready  output  1  the block accepts bit_in this cycle; a bit is consumed only when bit_valid=1 and bit_ready=1.
REQ-008 cfg_abort  input  1  synchronous frame abort.
REQ-009 enable  output  1  write strobe to the downstream decoder bus.
REQ-010 address  output  [0:ADDR_WIDTH-1]  write address; address[0] is the MSB.
REQ-011 data_in  output  1  write data bit.
REQ-012 busy  output  1  a frame is in progress.
REQ-013 done  output  1  one-cycle pulse on frame completion.

Function
REQ-014 FSM states SHALL be IDLE, HDR_ADDR, HDR_CNT, DATA, SETUP, STROBE, DONE.
REQ-015 In IDLE, accepted bits of value 0 SHALL be discarded as filler, and an accepted bit of value 1 SHALL be the start marker -> HDR_ADDR.
REQ-016 HDR_ADDR SHALL collect ADDR_WIDTH accepted bits MSB-first into the start address -> HDR_CNT.
REQ-017 HDR_CNT SHALL collect CNT_WIDTH accepted bits MSB-first into the remaining count.
  - count nonzero -> DATA.
  - count zero -> DONE, with no writes.
REQ-018 DATA SHALL wait for one accepted bit, latch it as the write data, then go to SETUP.
REQ-019 SETUP SHALL last one cycle with address and data_in driving the current address and data and enable=0 -> STROBE.
REQ-020 STROBE SHALL last one cycle with enable=1 and address and data_in held stable from SETUP.
  - After STROBE, the address increments by 1 modulo 2^ADDR_WIDTH (15 wraps to 0) and the count decrements by 1.
  - New count nonzero -> DATA; new count zero -> DONE.
REQ-021 DONE SHALL last one cycle with done=1 -> IDLE.
REQ-022 bit_ready SHALL be 1 in IDLE, HDR_ADDR, HDR_CNT and DATA, and 0 in SETUP, STROBE and DONE.
REQ-023 bit_ready SHALL be forced to 0 whenever cfg_abort=1.
REQ-024 bit_valid=0 SHALL stall any collecting state indefinitely, with partial header state preserved.
REQ-025 enable SHALL be 1 only in STROBE, giving exactly one enable pulse per data bit.
  - Minimum spacing is 3 cycles per bit: DATA, SETUP, STROBE.
REQ-026 address and data_in SHALL hold their last driven values outside SETUP and STROBE.
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 cfg_abort=1 SHALL force the next state to IDLE from any state.
  - Abort takes priority over a simultaneous handshake or state transition.
  - An abort in STROBE still completes that cycle's enable pulse.
  - done SHALL NOT be asserted on abort.
  - address and data_in retain their values.
REQ-029 The count SHALL be held in CNT_WIDTH bits, the address in ADDR_WIDTH bits, and header bit counters SHALL be wide enough for max(ADDR_WIDTH, CNT_WIDTH).
REQ-030 A count larger than 2^ADDR_WIDTH SHALL be legal; writes wrap and overwrite earlier addresses.

Reset
REQ-031 While prog_rst_n=0, the following SHALL take their reset values immediately, independent of prog_clk:
  - state = IDLE.
  - enable = 0, address = 0, data_in = 0.
  - busy = 0, done = 0, bit_ready = 0.
  - count and bit counters = 0.
REQ-032 The first rising edge of prog_clk after prog_rst_n deasserts SHALL leave the block in IDLE with bit_ready=1.
REQ-033 Reset asserted mid-frame SHALL discard the frame, with no further enable pulse.

Verification
REQ-034 Stream 0,0,1 | 0,1,0,1 | 00000011 | 1,0,1 with bit_valid=1 -> enable pulses at address 5, 6, 7 with data_in 1, 0, 1; then done pulses once; then IDLE.
REQ-035 Header address 1111, count 00000011, data 1,1,0 -> writes at addresses 15, 0, 1 (wrap-around).
REQ-036 Count 00000000 -> no enable pulse; done pulses exactly one cycle after the last count bit is accepted.
REQ-037 bit_valid toggled randomly during header and data, with bit_in changing while bit_valid=0 -> writes identical to REQ-034; bit_ready=0 observed in every SETUP, STROBE and DONE cycle.
REQ-038 cfg_abort=1 in the same cycle as the second DATA handshake of a 3-bit frame -> that bit is not consumed, no further enable pulse, done stays 0, IDLE next cycle.
REQ-039 prog_rst_n pulled low asynchronously during STROBE -> enable falls to 0 without a clock edge; after release, a fresh REQ-034 frame completes correctly.
